// File: rtl/dropout_pkg.sv
// dropout_pkg: shared LFSR constants, mask FSM states and the Galois step function.
package dropout_pkg;
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;
  typedef enum logic [1:0] {IDLE, BUILD, HOLD} mask_state_t;
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction
endpackage

// File: rtl/dropout_mask_gen_if.sv
// dropout_mask_gen_if: valid/ready mask channel between the generator and the dropout stage.
interface dropout_mask_gen_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] mask_out;
  logic mask_valid;
  logic mask_ready;
  modport master (output mask_out, mask_valid, input mask_ready);
  modport slave (input mask_out, mask_valid, output mask_ready);
endinterface

// File: rtl/dropout_lfsr16.sv
// dropout_lfsr16: single-step Galois LFSR with enable, load and zero-seed substitution.
module dropout_lfsr16
  import dropout_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic [7:0]        nxt_lo
);
  logic [LFSR_W-1:0] q;
  logic [LFSR_W-1:0] nxt;
  assign nxt = lfsr_step(q);
  assign nxt_lo = nxt[7:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= SEED;
    else if (load) q <= (seed_in == '0) ? SEED : seed_in;
    else if (en) q <= nxt;
endmodule

// File: rtl/dropout_mask_gen.sv
// dropout_mask_gen: serial LFSR keep-mask builder with valid/ready output.
// Optional drop-bit statistics counter under DROPOUT_MASK_STATS_EN.
module dropout_mask_gen
  import dropout_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter logic [15:0] SEED  = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  input  logic [7:0]  drop_rate,
  dropout_mask_gen_if.master m
`ifdef DROPOUT_MASK_STATS_EN
  ,
  output logic [15:0] drop_cnt
`endif
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  mask_state_t state, state_n;
  logic [IDX_W-1:0] bit_idx, bit_idx_n;
  logic [7:0] rate_q, rate_n;
  logic [WIDTH-1:0] mask_sr, mask_sr_n, mask_q, mask_n;
  logic [7:0] lfsr_nxt;
  logic step, keep, hs, last, restart;
  assign step = enable && state == BUILD && !seed_load;
  assign keep = lfsr_nxt >= rate_q;
  assign hs = m.mask_valid && m.mask_ready;
  assign last = bit_idx == IDX_W'(WIDTH - 1);
  assign restart = seed_load || (state == IDLE && enable) || (state == HOLD && hs);
  assign m.mask_valid = state == HOLD;
  assign m.mask_out = mask_q;
  dropout_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk(clk),
    .reset(reset),
    .en(step),
    .load(seed_load),
    .seed_in(seed_in),
    .nxt_lo(lfsr_nxt)
  );
  // every mask start (seed load, leaving IDLE, handshake) relatches the rate and clears the build
  always_comb begin
    state_n = state;
    bit_idx_n = bit_idx;
    rate_n = rate_q;
    mask_sr_n = mask_sr;
    mask_n = mask_q;
    if (restart) begin
      state_n = enable ? BUILD : IDLE;
      rate_n = drop_rate;
      bit_idx_n = '0;
      mask_sr_n = '0;
    end else if (step) begin
      mask_sr_n[bit_idx] = keep;
      bit_idx_n = last ? '0 : bit_idx + 1'b1;
      state_n = last ? HOLD : BUILD;
      mask_n = last ? mask_sr_n : mask_q;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bit_idx <= '0;
      rate_q <= '0;
      mask_sr <= '0;
      mask_q <= '0;
    end else begin
      state <= state_n;
      bit_idx <= bit_idx_n;
      rate_q <= rate_n;
      mask_sr <= mask_sr_n;
      mask_q <= mask_n;
    end
`ifdef DROPOUT_MASK_STATS_EN
  logic [16:0] zeros, sum;
  assign zeros = 17'(WIDTH - $countones(mask_q));
  assign sum = {1'b0, drop_cnt} + zeros;
  always_ff @(posedge clk or posedge reset)
    if (reset) drop_cnt <= '0;
    else if (seed_load) drop_cnt <= '0;
    else if (hs) drop_cnt <= sum[16] ? 16'hFFFF : sum[15:0];
`endif
endmodule
